// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the scanning N:1 channel mux.
// The MUX_SCAN_MASK_EN build option (per-channel enable mask) is handled in mux_scan_nx1.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Wrapping search for the nearest enabled channel above cur_ch.
// wrap is set when the search falls back to the lowest enabled channel.
module mux_scan_next_ch
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic [SEL_W-1:0]  cur_ch,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  next_ch,
    output logic              wrap,
    output logic              any_en
);

    logic             found_above;
    logic             found_low;
    logic [SEL_W-1:0] above_ch;
    logic [SEL_W-1:0] low_ch;

    // Descending walk: the last hit in each class is its lowest index.
    always_comb begin
        found_above = 1'b0;
        found_low   = 1'b0;
        above_ch    = '0;
        low_ch      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                found_low = 1'b1;
                low_ch    = SEL_W'(i);
                if (SEL_W'(i) > cur_ch) begin
                    found_above = 1'b1;
                    above_ch    = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        next_ch = cur_ch;
        wrap    = 1'b0;
        any_en  = found_low;
        if (found_above) begin
            next_ch = above_ch;
        end else if (found_low) begin
            next_ch = low_ch;
            wrap    = 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N:1 channel mux with manual select and auto-scan with programmable dwell.
// Define MUX_SCAN_MASK_EN to add the ch_mask port (scan skips disabled channels).
//
// state     | meaning
// ST_MANUAL | output follows sel every cycle
// ST_SCAN   | output steps through enabled channels, dwell+1 cycles each
module mux_scan_nx1
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 1,
    parameter int DWELL_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    input  logic [DWELL_W-1:0]       dwell,
`ifdef MUX_SCAN_MASK_EN
    input  logic [NUM_CH-1:0]        ch_mask,
`endif
    output logic [DATA_W-1:0]        data_out,
    output logic [SEL_W-1:0]         ch_out,
    output logic                     ch_valid,
    output logic                     wrap
);

    state_t             state;
    state_t             state_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [SEL_W-1:0]   ch_nxt;
    logic               valid_nxt;
    logic               wrap_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic [DATA_W-1:0]  ch_data;
    logic               sel_en;
    logic [NUM_CH-1:0]  mask_eff;
    logic [SEL_W-1:0]   scan_ch;
    logic               scan_wrap;
    logic               any_en;

`ifdef MUX_SCAN_MASK_EN
    assign mask_eff = ch_mask;
`else
    assign mask_eff = '1;
`endif

    mux_scan_next_ch #(
        .NUM_CH (NUM_CH)
    ) u_next_ch (
        .cur_ch  (ch_out),
        .mask    (mask_eff),
        .next_ch (scan_ch),
        .wrap    (scan_wrap),
        .any_en  (any_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_MANUAL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        ch_nxt    = ch_out;
        cnt_nxt   = '0;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        case (state)
            ST_MANUAL: begin
                // Entering scan keeps the current channel, so no strobe.
                if (mode == MODE_MANUAL) begin
                    ch_nxt    = sel;
                    valid_nxt = (sel != ch_out);
                end
            end
            ST_SCAN: begin
                if (mode == MODE_MANUAL) begin
                    ch_nxt    = sel;
                    valid_nxt = (sel != ch_out);
                end else if (cnt >= dwell) begin
                    if (any_en) begin
                        ch_nxt    = scan_ch;
                        valid_nxt = 1'b1;
                        wrap_nxt  = scan_wrap;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_MANUAL;
            end
        endcase
    end

    // Data is taken from the channel being registered this edge, so it lines up with ch_out.
    always_comb begin
        ch_data = '0;
        sel_en  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_nxt == SEL_W'(i)) begin
                ch_data = data_in[i*DATA_W +: DATA_W];
                sel_en  = mask_eff[i];
            end
        end
        data_nxt = '0;
        // In scan, a freshly disabled channel still finishes its dwell.
        if ((mode == MODE_SCAN) ? any_en : sel_en) begin
            data_nxt = ch_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            ch_out   <= '0;
            data_out <= '0;
            ch_valid <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            ch_out   <= ch_nxt;
            data_out <= data_nxt;
            ch_valid <= valid_nxt;
            wrap     <= wrap_nxt;
        end
    end

endmodule

// File: doc/mux_scan_nx1.md
# mux_scan_nx1

Parametrised, registered N-to-1 multiplexer of DATA_W-bit channels, the successor to our fixed 4-bit, 1-bit-output combinational mux. Adds a registered output, an auto-scan mode that steps through channels with a programmable dwell time, and per-channel status strobes. It sits between the sensor and status input banks and the downstream single-lane consumers (display driver, serial logger) that must observe every channel in turn.

## Interface
- NUM_CH, 4: number of input channels, ≥2.
- DATA_W, 1: bits per channel.
- DWELL_W, 8: width of the dwell setting.
- SEL_W, derived: $clog2(NUM_CH); not overridable.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  NUM_CH*DATA_W  channel i occupies [i*DATA_W +: DATA_W].
- sel  in  SEL_W  channel select, used in manual mode.
- mode  in  1  0 = manual, 1 = scan.
- dwell  in  DWELL_W  scan mode holds each channel for dwell+1 cycles.
- ch_mask  in  NUM_CH  per-channel enable, 1 = enabled. Present only with MUX_SCAN_MASK_EN.
- data_out  out  DATA_W  registered selected data.
- ch_out  out  SEL_W  index of the channel currently driving data_out.
- ch_valid  out  1  one-cycle pulse on the first cycle data_out carries a newly selected channel.
- wrap  out  1  one-cycle pulse, coincident with ch_valid, when scan steps from the highest enabled channel to the lowest.

## Operation
- Reset values: data_out=0, ch_out=0, ch_valid=0, wrap=0, dwell counter=0, state=MANUAL.
- FSM has two states, MANUAL and SCAN, and follows `mode` each cycle.
- MANUAL:
  - data_out <= channel `sel` and ch_out <= sel every cycle.
  - If sel ≥ NUM_CH: data_out <= 0 and ch_out <= sel.
  - ch_valid pulses when the registered ch_out changes value.
  - wrap stays 0.
- MANUAL→SCAN:
  - Scanning starts at the current ch_out and the dwell counter clears to 0.
  - There is no ch_valid pulse, because the channel is unchanged.
- SCAN:
  - data_out <= channel ch_out every cycle (live sampling, not a snapshot).
  - The counter increments each cycle.
  - When counter ≥ dwell: counter <= 0, ch_out <= next channel, ch_valid pulses.
  - After NUM_CH-1 the next channel is 0, and wrap pulses.
- SCAN→MANUAL: on the next edge, ch_out <= sel and the counter clears. ch_valid pulses if the channel changes.
- dwell changed mid-count: the comparison uses the live value. If the counter already exceeds the new dwell, the channel advances on the next edge.
- dwell=0: the channel advances every cycle and ch_valid stays high continuously.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronous). Scanning resumes from channel 0 after release.

## Timing
- Latency from data_in, sel or mode to data_out and ch_out is 1 cycle, with no combinational path to outputs.
- In scan mode each channel is presented for exactly dwell+1 consecutive cycles, provided dwell is held stable.
- One full scan of n enabled channels takes n*(dwell+1) cycles, and wrap recurs at that period.
- ch_valid and wrap are registered and aligned with the first data_out cycle of the new channel.

## Configuration
- MUX_SCAN_MASK_EN defined:
  - The ch_mask port exists.
  - Scan skips disabled channels. The next channel is the nearest enabled index above ch_out, wrapping at NUM_CH-1. wrap pulses when that search wraps.
  - In manual mode a disabled selection gives data_out=0, with ch_out=sel.
  - With all channels disabled: data_out=0, ch_out holds, no ch_valid or wrap pulses.
  - A mask change takes effect at the next advance. The current channel is not cut short.
- Undefined: the port is absent, all channels are treated as enabled, and the next-channel logic reduces to an increment with wrap.

## Structure
- Package mux_scan_pkg:
  - MODE_MANUAL/MODE_SCAN constants.
  - state enum {ST_MANUAL, ST_SCAN}.
- Sub-module mux_scan_next_ch: combinational wrapping search for the next enabled channel, taking ch_out and the mask and returning the next index plus a wrap flag. Without the macro it is instantiated with an all-ones mask.

## Test plan
- Reset, then release with mode=0, sel=2, NUM_CH=4, DATA_W=8, data_in={8'h44,8'h33,8'h22,8'h11}:
  - Cycle 1: data_out=8'h33, ch_out=2, one ch_valid pulse.
- mode=1, dwell=2, from ch_out=0:
  - ch_out follows 0,0,0,1,1,1,2,2,2,3,3,3,0.
  - ch_valid fires every 3 cycles.
  - wrap fires only on 3→0.
- Scan with dwell=5, dwell changed to 1 when the counter is at 4 → advance on the next edge, then a 2-cycle dwell.
- Assert rst mid-scan at ch_out=2 → outputs 0 with no clock edge needed; after release scanning restarts at 0.
- MUX_SCAN_MASK_EN, ch_mask=4'b1010, dwell=0 → ch_out alternates 1,3,1,3 and wrap pulses on every 3→1.
- MUX_SCAN_MASK_EN, ch_mask=0 → data_out=0, ch_valid=0 for at least 10 cycles.
- MUX_SCAN_MASK_EN, then ch_mask=4'b0100 → on the next advance ch_out=2.
